// File: rtl/stall_pipeline_pkg.sv
// ============================================================================
// Module : stall_pipeline_pkg
// Brief  : Shared depth and occupancy-width constants for stall_pipeline.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package stall_pipeline_pkg;

    localparam int PIPE_DEPTH = 3;
    localparam int OCC_W      = $clog2(PIPE_DEPTH + 1);

endpackage : stall_pipeline_pkg

`default_nettype wire

// File: rtl/stall_pipeline_pipe_stage.sv
// ============================================================================
// Module : pipe_stage
// Brief  : One valid+data slice of the backpressured pipeline.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_stage #(
    parameter int WIDTH = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             up_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // An empty slot always accepts, so bubbles collapse under a stalled output.
    assign up_ready = !valid_q || dn_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (up_ready) begin
            valid_d = up_valid;
            data_d  = up_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule : pipe_stage

`default_nettype wire

// File: rtl/stall_pipeline.sv
// ============================================================================
// Module : stall_pipeline
// Brief  : Three-stage valid/ready register pipeline with flush and occupancy.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module stall_pipeline
    import stall_pipeline_pkg::*;
#(
    parameter int WIDTH = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] datain,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataout,
    output logic [OCC_W-1:0] occupancy
);

    logic             w_v0;
    logic             w_v1;
    logic             w_v2;
    logic             w_v3;
    logic [WIDTH-1:0] w_d1;
    logic [WIDTH-1:0] w_d2;
    logic [WIDTH-1:0] w_d3;
    logic             w_r1;
    logic             w_r2;
    logic             w_r3;

    // Flush blocks the incoming word as well as clearing the held ones.
    assign w_v0     = in_valid && !flush;
    assign in_ready = w_r1 && !flush;

    pipe_stage #(.WIDTH(WIDTH)) u_stage1 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .up_valid (w_v0),
        .up_data  (datain),
        .dn_ready (w_r2),
        .up_ready (w_r1),
        .valid    (w_v1),
        .data     (w_d1)
    );

    pipe_stage #(.WIDTH(WIDTH)) u_stage2 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .up_valid (w_v1),
        .up_data  (w_d1),
        .dn_ready (w_r3),
        .up_ready (w_r2),
        .valid    (w_v2),
        .data     (w_d2)
    );

    pipe_stage #(.WIDTH(WIDTH)) u_stage3 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .up_valid (w_v2),
        .up_data  (w_d2),
        .dn_ready (out_ready),
        .up_ready (w_r3),
        .valid    (w_v3),
        .data     (w_d3)
    );

    assign out_valid = w_v3;
    assign dataout   = w_d3;
    assign occupancy = OCC_W'(w_v1) + OCC_W'(w_v2) + OCC_W'(w_v3);

endmodule : stall_pipeline

`default_nettype wire

// File: tb/tb_stall_pipeline.sv
// ============================================================================
// Module : tb_stall_pipeline
// Brief  : Scoreboard bench for stall_pipeline with directed vectors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_stall_pipeline;
    import stall_pipeline_pkg::*;

    localparam int W = 100;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     datain;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     dataout;
    logic [OCC_W-1:0] occupancy;

    int               checks;
    int               failures;
    int               n_out;
    logic [W-1:0]     sb_q[$];
    logic             stalled;
    logic [W-1:0]     held_data;

    stall_pipeline #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, between active edges.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 128'(out_valid), 128'(1'b1));
                chk("hold_data", 128'(dataout), 128'(held_data));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 128'(dataout), 128'(0));
                    checks++;
                    failures++;
                    $display("FAIL spurious_out: got %0h expected no word", dataout);
                end else begin
                    chk("sb_order", 128'(dataout), 128'(sb_q.pop_front()));
                end
            end
            if (in_valid && in_ready) sb_q.push_back(datain);
            if (flush) sb_q.delete();
            stalled   = out_valid && !out_ready && !flush;
            held_data = dataout;
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int c = 0; c < 20 && occupancy != 0; c++) edge1();
        chk("drain_empty", 128'(occupancy), 128'(0));
        chk("sb_empty", 128'(sb_q.size()), 128'(0));
    endtask

    initial begin
        logic [W-1:0] sw [4];
        int  j;
        int  n0;
        logic acc;

        checks    = 0;
        failures  = 0;
        n_out     = 0;
        stalled   = 1'b0;
        held_data = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        datain    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_dataout", 128'(dataout), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        edge1();
        rst = 1'b0;

        // Streaming: 1..4 back to back, three-edge latency, no gaps.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            datain   = W'(i);
            edge1();
            if (i == 2) chk("lat_not_early", 128'(out_valid), 128'(0));
            if (i == 3) begin
                chk("lat_valid", 128'(out_valid), 128'(1));
                chk("lat_data", 128'(dataout), 128'(1));
            end
            if (i == 4) chk("stream_d2", 128'(dataout), 128'(2));
        end
        in_valid = 1'b0;
        edge1();
        chk("stream_d3", 128'(dataout), 128'(3));
        edge1();
        chk("stream_d4", 128'(dataout), 128'(4));
        drain();

        // Stall and fill, then release in order.
        sw[0] = W'(32'hA); sw[1] = W'(32'hB); sw[2] = W'(32'hC); sw[3] = W'(32'hD);
        out_ready = 1'b0;
        j = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            datain   = sw[j];
            #1 acc = in_ready;
            edge1();
            if (acc) j++;
        end
        chk("fill_accepted", 128'(j), 128'(3));
        chk("fill_in_ready", 128'(in_ready), 128'(0));
        chk("fill_occ", 128'(occupancy), 128'(PIPE_DEPTH));
        chk("fill_head", 128'(dataout), 128'(32'hA));
        out_ready = 1'b1;
        for (int c = 0; c < 10 && j < 4; c++) begin
            datain = sw[j];
            #1 acc = in_ready;
            edge1();
            if (acc) j++;
        end
        chk("release_all_in", 128'(j), 128'(4));
        drain();

        // Bubble collapse: 5, gap, gap, 6 under a stalled output.
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 0 || c == 3);
            datain   = (c == 0) ? W'(5) : W'(6);
            edge1();
        end
        in_valid = 1'b0;
        chk("bubble_occ", 128'(occupancy), 128'(2));
        chk("bubble_head", 128'(dataout), 128'(5));
        chk("bubble_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        edge1();
        chk("bubble_adjacent", 128'(dataout), 128'(6));
        drain();

        // Full with simultaneous accept and deliver.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            datain   = W'(32'h10 + k);
            edge1();
        end
        chk("full_occ", 128'(occupancy), 128'(3));
        out_ready = 1'b1;
        n0 = n_out;
        for (int k = 0; k < 4; k++) begin
            datain = W'(32'h13 + k);
            #1 chk("full_in_ready", 128'(in_ready), 128'(1));
            edge1();
            chk("full_occ_hold", 128'(occupancy), 128'(3));
        end
        chk("full_out_count", 128'(n_out - n0), 128'(4));

        // Flush with a word offered: nothing survives, 0x7 never appears.
        flush  = 1'b1;
        datain = W'(7);
        #1 chk("flush_in_ready", 128'(in_ready), 128'(0));
        edge1();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", 128'(occupancy), 128'(0));
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        for (int c = 0; c < 4; c++) edge1();
        chk("flush_quiet", 128'(out_valid), 128'(0));

        // Asynchronous reset mid-cycle with two words in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            datain   = W'(32'h20 + k);
            edge1();
        end
        in_valid = 1'b0;
        chk("pre_rst_occ", 128'(occupancy), 128'(2));
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_dataout", 128'(dataout), 128'(0));
        chk("arst_occ", 128'(occupancy), 128'(0));
        edge1();
        rst = 1'b0;
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        datain   = W'(32'h30);
        out_ready = 1'b1;
        edge1();
        drain();

        edge1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule : tb_stall_pipeline

`default_nettype wire

// File: doc/stall_pipeline.md
# stall_pipeline

Three-stage, WIDTH-bit register pipeline with valid/ready flow control on both ends, so a slow downstream consumer can stall it without losing or duplicating data. It is the backpressured counterpart to the free-running three-stage pipeline in the PipelineAdder lab. It sits between a producer that asserts `in_valid` and a consumer that throttles with `out_ready`. Bubbles collapse: an empty stage always accepts from the stage upstream of it, even while the output is stalled.

## Interface
- `WIDTH`, default 100: data bit width.
- `clk`  input  1: single clock; all registers update on its rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `in_valid`  input  1: `datain` holds a word to be accepted.
- `in_ready`  output  1: the pipeline accepts `datain` on this edge.
- `datain`  input  WIDTH: input word.
- `flush`  input  1: synchronous discard of all held words.
- `out_valid`  output  1: `dataout` holds a valid word.
- `out_ready`  input  1: the consumer takes `dataout` on this edge.
- `dataout`  output  WIDTH: output word; this is stage-3 data.
- `occupancy`  output  2: number of valid stages, 0–3.

## Operation
- Each stage k (k = 1..3) holds a valid bit `v_k` and a data register `d_k`.
- Ready chain, all combinational:
  - `r_4 = out_ready`
  - `r_k = !v_k | r_{k+1}`
  - `in_ready = r_1 & !flush`
- On each edge where `r_k` = 1, stage k loads the contents of stage k-1: `v_k <= v_{k-1}` and `d_k <= d_{k-1}`. Stage 0 is `in_valid & !flush` with data `datain`.
- When `r_k` = 0, stage k holds both its valid bit and its data.
- A word transfers at input when `in_valid & in_ready`. It transfers at output when `out_valid & out_ready`.
- When a stage loads with an upstream valid bit of 0, it becomes empty. Its data register may still be written; that content is don't-care.
- `out_valid = v_3`, `dataout = d_3`.
- `occupancy = v_1 + v_2 + v_3`, combinational.
- `flush` = 1 at an edge:
  - all `v_k` clear to 0;
  - no input is accepted;
  - any output handshake in that cycle still counts as consumed.
  - `flush` takes priority over every other action.
- `rst` = 1 (asynchronous): all `v_k` = 0 and all `d_k` = 0 immediately. Resulting outputs: `out_valid` = 0, `dataout` = 0, `occupancy` = 0, `in_ready` = 1 (when `flush` = 0).
- Reset asserted mid-stream drops all in-flight words. No partial state survives.

## Timing
- Latency: a word accepted at edge N appears on `dataout` with `out_valid` = 1 after edge N+2, i.e. 3 register stages, with no stall.
- Throughput: 1 word per cycle while `out_ready` = 1.
- Full (occupancy 3) with `out_ready` = 0: `in_ready` = 0 and all stages hold.
- Full with `out_ready` = 1: simultaneous accept and deliver. Occupancy stays 3 and `in_ready` = 1.
- Bubble fill: with output stalled and a gap in the stream, upstream words advance into empty stages. `in_ready` stays 1 until all 3 stages are valid.
- Empty: `out_valid` = 0; the value of `out_ready` is ignored.
- `out_valid` and `dataout` must stay stable while `out_valid & !out_ready`.
- `in_ready` depends combinationally on `out_ready`. This is a single combinational path with no loop.

## Structure
- Shared package/header: `PIPE_DEPTH` = 3 and the occupancy width constant. The bench reads both.
- Sub-module `pipe_stage` (`WIDTH`): one valid+data slice.
  - Ports: `clk`, `rst`, `flush`, `up_valid`, `up_data`, `dn_ready`, `up_ready`, `valid`, `data`.
  - Instantiated 3 times and chained by the top level.
- Top level: ready chain, flush gating, occupancy adder.

## Test plan
- Reset: assert `rst` mid-cycle with 2 words in flight → `out_valid`, `dataout` and `occupancy` go to 0 immediately. After release, `in_ready` = 1.
- Streaming: `out_ready` = 1, send 0x1, 0x2, 0x3, 0x4 on consecutive edges → 0x1 appears with `out_valid` after the 3rd edge, then 0x2, 0x3, 0x4 on consecutive cycles. No gaps.
- Stall/fill: `out_ready` = 0, offer 0xA, 0xB, 0xC, 0xD continuously.
  - 0xA–0xC are accepted; `in_ready` drops once occupancy = 3; `dataout` holds 0xA.
  - Raise `out_ready` → order is 0xA, 0xB, 0xC, 0xD, with no loss and no duplication.
- Bubble collapse: send 0x5, idle 2 cycles, send 0x6, with `out_ready` = 0 → occupancy reaches 2 and both words are adjacent in stages 3 and 2.
- Full with simultaneous handshake: occupancy 3, `in_valid` = 1, `out_ready` = 1 for 4 cycles → 4 words out, 4 words in, occupancy stays 3.
- Flush: occupancy 3 with `flush` = 1 and `in_valid` = 1 carrying 0x7 → after the edge occupancy = 0 and `out_valid` = 0. 0x7 is never output.
